// File: rtl/branch_predictor.sv
// branch_predictor
//   Fetch-side dynamic branch predictor. A bimodal table of 2-bit saturating
//   counters is paired with a direct-mapped branch target buffer (BTB). The
//   fetch PC is looked up combinationally every cycle. Execute's resolved
//   conditional-branch outcome trains both tables. Two statistics counters
//   track resolved branches and mispredicts.
//
//   Ports
//     clk                 clock; all state updates on the rising edge
//     rst_n               synchronous active-low reset
//     pc_f_i              fetch PC to predict
//     predict_taken_o     predicted taken for pc_f_i
//     predict_target_o    predicted target (zero when not predicted taken)
//     update_en_i         execute presents a resolved conditional branch
//     update_pc_i         PC of the resolved branch
//     update_taken_i      actual outcome of the resolved branch
//     update_target_i     computed target of the resolved branch
//     mispredict_i        execute flagged this branch as mispredicted
//     stat_branches_o     resolved conditional branches since reset
//     stat_mispredicts_o  mispredicts since reset
//
//   Handshake: update_en_i is a valid with no ready. The predictor accepts an
//   update in every cycle in which update_en_i is high, and it samples the
//   update_* and mispredict_i inputs only in those cycles. The lookup has no
//   handshake. Its outputs are a pure function of pc_f_i and the registered
//   state.
module branch_predictor #(
   parameter int         INDEX_BITS = 6,
   parameter logic [1:0] CTR_INIT   = 2'b01
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] pc_f_i,
   output logic        predict_taken_o,
   output logic [31:0] predict_target_o,
   input  logic        update_en_i,
   input  logic [31:0] update_pc_i,
   input  logic        update_taken_i,
   input  logic [31:0] update_target_i,
   input  logic        mispredict_i,
   output logic [31:0] stat_branches_o,
   output logic [31:0] stat_mispredicts_o
);

   localparam int DEPTH = 1 << INDEX_BITS;
   localparam int TAG_W = 30 - INDEX_BITS;

   logic [1:0]       ctr_q    [DEPTH];
   logic             valid_q  [DEPTH];
   logic [TAG_W-1:0] tag_q    [DEPTH];
   logic [31:0]      target_q [DEPTH];
   logic [31:0]      branches_q, branches_d;
   logic [31:0]      mispredicts_q, mispredicts_d;

   logic [INDEX_BITS-1:0] look_idx, upd_idx;
   logic [TAG_W-1:0]      look_tag, upd_tag;
   logic                  look_hit;
   logic [1:0]            ctr_upd_d;

   // Byte-offset bits of both PCs never take part in indexing or tagging.
   logic unused_pc_lsbs;
   assign unused_pc_lsbs = ^{pc_f_i[1:0], update_pc_i[1:0]};

   assign look_idx = pc_f_i[INDEX_BITS+1:2];
   assign look_tag = pc_f_i[31:INDEX_BITS+2];
   assign upd_idx  = update_pc_i[INDEX_BITS+1:2];
   assign upd_tag  = update_pc_i[31:INDEX_BITS+2];

   // Lookup reads the registered state only. A same-cycle update to the same
   // index is not bypassed, so the lookup sees the pre-update entry.
   assign look_hit         = valid_q[look_idx] && (tag_q[look_idx] == look_tag);
   assign predict_taken_o  = look_hit && ctr_q[look_idx][1];
   assign predict_target_o = predict_taken_o ? target_q[look_idx] : 32'h0;

   assign stat_branches_o    = branches_q;
   assign stat_mispredicts_o = mispredicts_q;

   // The counter is trained per index with no tag check. Aliasing branches
   // share one direction history.
   always_comb begin
      ctr_upd_d = ctr_q[upd_idx];
      if (update_taken_i) begin
         if (ctr_q[upd_idx] != 2'b11) ctr_upd_d = ctr_q[upd_idx] + 2'b01;
      end else begin
         if (ctr_q[upd_idx] != 2'b00) ctr_upd_d = ctr_q[upd_idx] - 2'b01;
      end
   end

   // Statistics saturate instead of wrapping.
   always_comb begin
      branches_d    = branches_q;
      mispredicts_d = mispredicts_q;
      if (update_en_i) begin
         if (branches_q != 32'hFFFF_FFFF) branches_d = branches_q + 32'd1;
         if (mispredict_i && (mispredicts_q != 32'hFFFF_FFFF))
            mispredicts_d = mispredicts_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            ctr_q[i]    <= CTR_INIT;
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= 32'h0;
         end
         branches_q    <= 32'h0;
         mispredicts_q <= 32'h0;
      end else begin
         branches_q    <= branches_d;
         mispredicts_q <= mispredicts_d;
         if (update_en_i) begin
            ctr_q[upd_idx] <= ctr_upd_d;
            // A taken branch always allocates and evicts any aliasing entry.
            // A not-taken branch leaves the BTB untouched.
            if (update_taken_i) begin
               valid_q[upd_idx]  <= 1'b1;
               tag_q[upd_idx]    <= upd_tag;
               target_q[upd_idx] <= update_target_i;
            end
         end
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor
//   Directed bench for branch_predictor. The driver pushes the
//   hand-computed expected outputs for a cycle into exp_q. It then raises
//   chk for that cycle. The monitor pops the queue on the falling edge and
//   compares the entry against the DUT outputs.
module tb_branch_predictor;

   logic        clk;
   logic        rst_n;
   logic [31:0] pc_f_i;
   logic        predict_taken_o;
   logic [31:0] predict_target_o;
   logic        update_en_i;
   logic [31:0] update_pc_i;
   logic        update_taken_i;
   logic [31:0] update_target_i;
   logic        mispredict_i;
   logic [31:0] stat_branches_o;
   logic [31:0] stat_mispredicts_o;

   // Expected entry layout: {taken, target, branches, mispredicts}
   logic [96:0] exp_q [$];
   string       name_q [$];
   logic        chk;
   int          n_cmp;
   int          n_bad;

   branch_predictor #(.INDEX_BITS(6), .CTR_INIT(2'b01)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .pc_f_i             (pc_f_i),
      .predict_taken_o    (predict_taken_o),
      .predict_target_o   (predict_target_o),
      .update_en_i        (update_en_i),
      .update_pc_i        (update_pc_i),
      .update_taken_i     (update_taken_i),
      .update_target_i    (update_target_i),
      .mispredict_i       (mispredict_i),
      .stat_branches_o    (stat_branches_o),
      .stat_mispredicts_o (stat_mispredicts_o)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      chk             = 1'b0;
      update_en_i     = 1'b0;
      update_taken_i  = 1'b0;
      update_pc_i     = 32'h0;
      update_target_i = 32'h0;
      mispredict_i    = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic upd(input logic [31:0] pc, input logic tk,
                      input logic [31:0] tgt, input logic mp);
      update_en_i     = 1'b1;
      update_pc_i     = pc;
      update_taken_i  = tk;
      update_target_i = tgt;
      mispredict_i    = mp;
   endtask

   task automatic expect_out(input string nm, input logic tk,
                             input logic [31:0] tgt,
                             input logic [31:0] br, input logic [31:0] mp);
      exp_q.push_back({tk, tgt, br, mp});
      name_q.push_back(nm);
      chk = 1'b1;
   endtask

   // ---------------- scoreboard / monitor ----------------
   task automatic cmp(input string nm, input string fld,
                      input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s.%s actual=0x%08h required=0x%08h", nm, fld, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL monitor actual=empty_queue required=entry");
         end else begin
            logic [96:0] e;
            string       nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            cmp(nm, "taken",  {31'h0, predict_taken_o}, {31'h0, e[96]});
            cmp(nm, "target", predict_target_o, e[95:64]);
            cmp(nm, "branches", stat_branches_o, e[63:32]);
            cmp(nm, "mispredicts", stat_mispredicts_o, e[31:0]);
         end
      end
   end

   task automatic report();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   endtask

   initial begin
      #200000;
      n_cmp++;
      n_bad++;
      $display("FAIL watchdog actual=timeout required=completion");
      report();
   end

   // ---------------- stimulus ----------------
   initial begin
      n_cmp = 0;
      n_bad = 0;
      chk = 1'b0;
      rst_n = 1'b0;
      pc_f_i = 32'h0;
      update_en_i = 1'b0;
      update_pc_i = 32'h0;
      update_taken_i = 1'b0;
      update_target_i = 32'h0;
      mispredict_i = 1'b0;

      // 1: reset state
      do_reset();
      pc_f_i = 32'h100;
      expect_out("reset", 1'b0, 32'h0, 32'd0, 32'd0);
      tick();

      // 2: one taken update, ctr 01->10, BTB allocated
      upd(32'h100, 1'b1, 32'h80, 1'b0);
      tick();
      expect_out("first_taken", 1'b1, 32'h80, 32'd1, 32'd0);
      tick();

      // 3: counter walks down and saturates at 00, then up and saturates at 11
      upd(32'h100, 1'b0, 32'h0, 1'b0); tick();           // 10->01
      upd(32'h100, 1'b0, 32'h0, 1'b0); tick();           // 01->00
      expect_out("two_not_taken", 1'b0, 32'h0, 32'd3, 32'd0);
      tick();
      upd(32'h100, 1'b0, 32'h0, 1'b0); tick();           // stays 00
      upd(32'h100, 1'b1, 32'h80, 1'b0); tick();          // 00->01
      expect_out("sat_low", 1'b0, 32'h0, 32'd5, 32'd0);
      tick();
      upd(32'h100, 1'b1, 32'h80, 1'b0); tick();          // 01->10
      upd(32'h100, 1'b1, 32'h80, 1'b0); tick();          // 10->11
      upd(32'h100, 1'b1, 32'h80, 1'b0); tick();          // stays 11
      expect_out("four_taken", 1'b1, 32'h80, 32'd8, 32'd0);
      tick();
      upd(32'h100, 1'b0, 32'h0, 1'b0); tick();           // 11->10
      expect_out("sat_high", 1'b1, 32'h80, 32'd9, 32'd0);
      tick();

      // 4: alias at index 0, tag 1 vs tag 2
      upd(32'h100, 1'b1, 32'h80, 1'b0); tick();
      upd(32'h200, 1'b1, 32'h40, 1'b0); tick();
      expect_out("alias_evicted", 1'b0, 32'h0, 32'd11, 32'd0);
      tick();
      pc_f_i = 32'h200;
      expect_out("alias_owner", 1'b1, 32'h40, 32'd11, 32'd0);
      tick();
      pc_f_i = 32'h202;
      expect_out("pc_lsbs_ignored", 1'b1, 32'h40, 32'd11, 32'd0);
      tick();

      // 5: same-cycle lookup sees pre-update state
      do_reset();
      pc_f_i = 32'h300;
      upd(32'h300, 1'b1, 32'h3F0, 1'b0);
      expect_out("same_cycle_1", 1'b0, 32'h0, 32'd0, 32'd0);
      tick();
      upd(32'h300, 1'b1, 32'h3F0, 1'b0);
      expect_out("same_cycle_2", 1'b1, 32'h3F0, 32'd1, 32'd0);
      tick();
      expect_out("after_two", 1'b1, 32'h3F0, 32'd2, 32'd0);
      tick();
      pc_f_i = 32'h104;
      expect_out("other_index", 1'b0, 32'h0, 32'd2, 32'd0);
      tick();

      // 6: mispredict counting, gated by update_en_i, then reset mid-update
      do_reset();
      pc_f_i = 32'h104;
      for (int i = 0; i < 3; i++) begin
         upd(32'h104, 1'b1, 32'h500, 1'b1);
         tick();
      end
      expect_out("mispredict_x3", 1'b1, 32'h500, 32'd3, 32'd3);
      tick();
      for (int i = 0; i < 2; i++) begin
         update_pc_i     = 32'h104;
         update_taken_i  = 1'b1;
         update_target_i = 32'h999;
         mispredict_i    = 1'b1;
         tick();
      end
      expect_out("en_low_ignored", 1'b1, 32'h500, 32'd3, 32'd3);
      tick();
      rst_n = 1'b0;
      upd(32'h104, 1'b1, 32'h700, 1'b1);
      tick();
      rst_n = 1'b1;
      expect_out("reset_wins", 1'b0, 32'h0, 32'd0, 32'd0);
      tick();

      tick();
      tick();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain actual=%0d required=0", exp_q.size());
      end
      report();
   end

endmodule
